// File: rtl/logarithm_pkg.sv
// logarithm_pkg: shared constants and types for the integer logarithm unit.
//   WIDTH      default operand width
//   RES_W      result / accumulator width (2*WIDTH)
//   CNT_W      exponent counter width (max result 15, one bit of margin)
//   log_state_t  controller states IDLE / CALC / DONE
package logarithm_pkg;

    localparam int WIDTH = 16;
    localparam int RES_W = 2 * WIDTH;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } log_state_t;

endpackage

// File: rtl/logarithm_dflip_en.sv
// dflip_en: generic enabled D register with asynchronous active-high reset.
//   clk  clock (rising edge)
//   rst  asynchronous reset, clears q to 0
//   en   load enable
//   d    next value
//   q    registered value
module dflip_en #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/logarithm.sv
// logarithm: iterative floor(log_b(x)) for unsigned operands.
// The accumulator starts at 1 and is multiplied by the base each CALC cycle
// while the product stays <= x; the number of accepted multiplies is the result.
//   clk, rst        clock, asynchronous active-high reset
//   log_start       start level, sampled only in IDLE
//   log_rst         synchronous clear back to IDLE (overrides everything but rst)
//   unsign_inputa   x, must stay stable until log_done
//   unsign_inputb   base b, must stay stable until log_done
//   log_busy        high while iterating
//   log_done        sticky completion flag, held until log_rst / rst
//   log_result      zero-extended exponent, valid while log_done
//   log_error       x == 0 or b < 2, valid while log_done
//   log_exact       (only with LOG_EXACT_EN) x is an exact power of b
// Optional feature macro: LOG_EXACT_EN.
module logarithm
    import logarithm_pkg::*;
#(
    parameter int WIDTH = logarithm_pkg::WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               log_start,
    input  logic               log_rst,
    input  logic [WIDTH-1:0]   unsign_inputa,
    input  logic [WIDTH-1:0]   unsign_inputb,
    output logic               log_busy,
    output logic               log_done,
    output logic [2*WIDTH-1:0] log_result,
`ifdef LOG_EXACT_EN
    output logic               log_exact,
`endif
    output logic               log_error
);

    localparam int AW = 2 * WIDTH;

    log_state_t       state_q, state_d;
    logic [1:0]       state_bits_q;
    logic [AW-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             acc_en, cnt_en, err_en;
    logic [AW-1:0]    x_ext, b_ext, prod;
`ifdef LOG_EXACT_EN
    logic             exact_q, exact_d, exact_en;
`endif

    assign state_q = log_state_t'(state_bits_q);
    assign x_ext   = {{WIDTH{1'b0}}, unsign_inputa};
    assign b_ext   = {{WIDTH{1'b0}}, unsign_inputb};
    // acc never exceeds x < 2^WIDTH, so the truncated product is exact.
    assign prod    = acc_q * b_ext;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        acc_en  = 1'b0;
        cnt_en  = 1'b0;
        err_en  = 1'b0;
`ifdef LOG_EXACT_EN
        exact_d  = exact_q;
        exact_en = 1'b0;
`endif
        if (log_rst) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
            acc_en  = 1'b1;
            cnt_en  = 1'b1;
            err_en  = 1'b1;
`ifdef LOG_EXACT_EN
            exact_d  = 1'b0;
            exact_en = 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (log_start) begin
                        cnt_d  = '0;
                        cnt_en = 1'b1;
                        err_en = 1'b1;
`ifdef LOG_EXACT_EN
                        exact_d  = 1'b0;
                        exact_en = 1'b1;
`endif
                        if (unsign_inputa == '0 || unsign_inputb < WIDTH'(2)) begin
                            state_d = DONE;
                            err_d   = 1'b1;
                        end else begin
                            state_d = CALC;
                            acc_d   = AW'(1);
                            acc_en  = 1'b1;
                            err_d   = 1'b0;
                        end
                    end
                end
                CALC: begin
                    if (prod > x_ext) begin
                        state_d = DONE;
`ifdef LOG_EXACT_EN
                        exact_d  = (acc_q == x_ext);
                        exact_en = 1'b1;
`endif
                    end else begin
                        acc_d  = prod;
                        acc_en = 1'b1;
                        cnt_d  = cnt_q + CNT_W'(1);
                        cnt_en = 1'b1;
                    end
                end
                // DONE holds until log_rst; a held log_start does not re-trigger.
                default: ;
            endcase
        end
    end

    dflip_en #(.W(2)) u_state (
        .clk (clk), .rst (rst), .en (1'b1), .d (state_d), .q (state_bits_q)
    );
    dflip_en #(.W(AW)) u_acc (
        .clk (clk), .rst (rst), .en (acc_en), .d (acc_d), .q (acc_q)
    );
    dflip_en #(.W(CNT_W)) u_cnt (
        .clk (clk), .rst (rst), .en (cnt_en), .d (cnt_d), .q (cnt_q)
    );
    dflip_en #(.W(1)) u_err (
        .clk (clk), .rst (rst), .en (err_en), .d (err_d), .q (err_q)
    );
`ifdef LOG_EXACT_EN
    dflip_en #(.W(1)) u_exact (
        .clk (clk), .rst (rst), .en (exact_en), .d (exact_d), .q (exact_q)
    );
    assign log_exact = exact_q & log_done;
`endif

    assign log_busy   = (state_q == CALC);
    assign log_done   = (state_q == DONE);
    assign log_result = log_done ? {{(AW-CNT_W){1'b0}}, cnt_q} : '0;
    assign log_error  = err_q & log_done;

endmodule

// File: tb/tb_logarithm.sv
module tb_logarithm;

    logic        clk = 1'b0;
    logic        rst;
    logic        log_start;
    logic        log_rst;
    logic [15:0] unsign_inputa;
    logic [15:0] unsign_inputb;
    logic        log_busy;
    logic        log_done;
    logic [31:0] log_result;
    logic        log_error;
`ifdef LOG_EXACT_EN
    logic        log_exact;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    logarithm dut (
        .clk           (clk),
        .rst           (rst),
        .log_start     (log_start),
        .log_rst       (log_rst),
        .unsign_inputa (unsign_inputa),
        .unsign_inputb (unsign_inputb),
        .log_busy      (log_busy),
        .log_done      (log_done),
        .log_result    (log_result),
`ifdef LOG_EXACT_EN
        .log_exact     (log_exact),
`endif
        .log_error     (log_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, {31'b0, log_busy}, 32'd0);
        chk({tag, "_done"}, {31'b0, log_done}, 32'd0);
        chk({tag, "_res"}, log_result, 32'd0);
        chk({tag, "_err"}, {31'b0, log_error}, 32'd0);
    endtask

    task automatic clear();
        log_start = 1'b0;
        log_rst   = 1'b1;
        tick();
        log_rst   = 1'b0;
    endtask

    // Start at a negedge with log_start held; count edges until log_done.
    task automatic run(input string tag, input logic [15:0] x, input logic [15:0] b,
                       input int exp_res, input bit exp_err, input bit exp_exact,
                       input int exp_edges);
        int n;
        unsign_inputa = x;
        unsign_inputb = b;
        log_start     = 1'b1;
        n = 0;
        while (n < 40 && !log_done) begin
            tick();
            n++;
        end
        chk({tag, "_edges"}, n, exp_edges);
        chk({tag, "_done"}, {31'b0, log_done}, 32'd1);
        chk({tag, "_res"}, log_result, exp_res);
        chk({tag, "_err"}, {31'b0, log_error}, {31'b0, exp_err});
        chk({tag, "_busy"}, {31'b0, log_busy}, 32'd0);
`ifdef LOG_EXACT_EN
        chk({tag, "_exact"}, {31'b0, log_exact}, {31'b0, exp_exact});
`else
        if (exp_exact) begin end
`endif
    endtask

    initial begin
        rst = 1'b1; log_start = 1'b0; log_rst = 1'b0;
        unsign_inputa = '0; unsign_inputb = '0;
        #12;
        chk_idle("reset");
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk_idle("post_reset");

        run("x1000_b10", 16'd1000, 16'd10, 3, 1'b0, 1'b1, 5);
        // start held through DONE: no recompute, outputs stay put
        repeat (5) tick();
        chk("hold_done", {31'b0, log_done}, 32'd1);
        chk("hold_res", log_result, 32'd3);
        chk("hold_busy", {31'b0, log_busy}, 32'd0);
        clear();
        chk_idle("clr1");

        run("x999_b10", 16'd999, 16'd10, 2, 1'b0, 1'b0, 4); clear();
        run("x65535_b2", 16'd65535, 16'd2, 15, 1'b0, 1'b0, 17); clear();
        run("x5_b7", 16'd5, 16'd7, 0, 1'b0, 1'b0, 2); clear();
        run("x1_b2", 16'd1, 16'd2, 0, 1'b0, 1'b1, 2); clear();
        run("x65536m_b256", 16'd65535, 16'd256, 1, 1'b0, 1'b0, 3); clear();
        run("x0_b10", 16'd0, 16'd10, 0, 1'b1, 1'b0, 1); clear();
        run("x8_b1", 16'd8, 16'd1, 0, 1'b1, 1'b0, 1); clear();
        run("x8_b0", 16'd8, 16'd0, 0, 1'b1, 1'b0, 1); clear();
        run("x8_b2", 16'd8, 16'd2, 3, 1'b0, 1'b1, 5); clear();

        // log_rst on the 4th CALC edge discards the partial result
        unsign_inputa = 16'd65535; unsign_inputb = 16'd2; log_start = 1'b1;
        tick();                       // edge 0: enter CALC
        chk("mid_busy", {31'b0, log_busy}, 32'd1);
        repeat (3) tick();            // CALC edges 1..3
        log_rst = 1'b1; log_start = 1'b0;
        tick();                       // CALC edge 4 with log_rst
        log_rst = 1'b0;
        chk_idle("lrst");
        repeat (20) tick();
        chk("lrst_nodone", {31'b0, log_done}, 32'd0);
        run("restart", 16'd65535, 16'd2, 15, 1'b0, 1'b0, 17); clear();

        // log_rst and log_start together in IDLE: log_rst wins
        log_start = 1'b1; log_rst = 1'b1;
        tick();
        log_rst = 1'b0; log_start = 1'b0;
        chk("sim_busy", {31'b0, log_busy}, 32'd0);
        chk("sim_done", {31'b0, log_done}, 32'd0);

        // asynchronous rst mid-CALC clears outputs before any clock edge
        unsign_inputa = 16'd65535; unsign_inputb = 16'd2; log_start = 1'b1;
        repeat (3) tick();
        chk("pre_arst_busy", {31'b0, log_busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk_idle("arst");
        log_start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) tick();
        chk("arst_nodone", {31'b0, log_done}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
